// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit for the EXE stage
// MULT/MULTU/DIV/DIVU on magnitudes, signs fixed up after DATA_W calc cycles.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_stall_req,
  output logic              o_done,
  output logic              o_div_by_zero,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_is_div;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_dbz;

  logic                w_start_ok;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_nxt;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_diff;
  logic                w_ge;
  logic [2*DATA_W-1:0] w_div_nxt;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quot_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  assign w_start_ok = (r_state == S_IDLE) & i_start & ~i_flush;
  assign w_a_neg    = ~i_op[0] & i_operand_a[DATA_W-1];
  assign w_b_neg    = ~i_op[0] & i_operand_b[DATA_W-1];
  assign w_a_mag    = w_a_neg ? -i_operand_a : i_operand_a;
  assign w_b_mag    = w_b_neg ? -i_operand_b : i_operand_b;

  // Multiply: accumulator upper half gains a when the multiplier LSB is set, then shifts right
  assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[DATA_W-1:1]};

  // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at the bottom
  assign w_rem_sh  = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_div_nxt = {(w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0]),
                      r_acc[DATA_W-2:0], w_ge};

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quot_fix = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_CALC;
      S_CALC: begin
        if (i_flush) w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = S_FIXUP;
      end
      S_FIXUP: w_state_nxt = i_flush ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else if (i_enable) begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_is_div  <= i_op[1];
            r_a       <= w_a_mag;
            r_b       <= w_b_mag;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= '0;
            r_acc     <= {{DATA_W{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIXUP: begin
          if (!i_flush) begin
            if (!r_is_div) begin
              r_hi  <= w_prod_fix[2*DATA_W-1:DATA_W];
              r_lo  <= w_prod_fix[DATA_W-1:0];
              r_dbz <= 1'b0;
            end else if (r_b == '0) begin
              r_hi  <= r_a;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi  <= w_rem_fix;
              r_lo  <= w_quot_fix;
              r_dbz <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_stall_req   = w_start_ok | (r_state == S_CALC) | (r_state == S_FIXUP);
  assign o_done        = (r_state == S_DONE);
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule
